// File: rtl/echo_delay_engine.sv
// rtl/echo_delay_engine.sv - feedback echo y[n] = x[n] + (coef/8)*y[n-D] with history RAM.
// Optional output clamping when ECHO_SATURATION_EN is defined; otherwise results wrap.
module echo_delay_engine #(
  parameter int WIDTH            = 12,
  parameter int ADDR_BITS        = 13,
  parameter int SAMPLES_PER_STEP = 240,
  parameter int DELAY_BITS       = 5,
  parameter int COEF_BITS        = 3
) (
  input  logic                    clock,
  input  logic                    reset_n,
  input  logic                    start,
  input  logic                    enable,
  input  logic signed [WIDTH-1:0] sample_in,
  input  logic [DELAY_BITS-1:0]   delay_amount,
  input  logic [COEF_BITS-1:0]    coef,
  output logic signed [WIDTH-1:0] sample_out,
  output logic                    done,
  output logic                    busy
);

  localparam int DEPTH = 2 ** ADDR_BITS;
  localparam int PW    = WIDTH + COEF_BITS;
  localparam logic [ADDR_BITS-1:0] MAX_D = ADDR_BITS'(DEPTH - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_BYPASS, S_READ, S_WAIT, S_SCALE, S_COMBINE
  } state_t;

  state_t                  state_q, state_d;
  logic signed [WIDTH-1:0] x_q, x_d;
  logic [COEF_BITS-1:0]    coef_q, coef_d;
  logic [DELAY_BITS-1:0]   delay_q, delay_d;
  logic [ADDR_BITS-1:0]    wr_ptr_q, wr_ptr_d;
  logic [ADDR_BITS-1:0]    fill_q, fill_d;
  logic signed [PW-1:0]    prod_q, prod_d;
  logic signed [WIDTH-1:0] sample_out_q, sample_out_d;
  logic                    done_q, done_d;
  logic                    busy_q, busy_d;

  logic [WIDTH-1:0]        mem [DEPTH];
  logic signed [WIDTH-1:0] mem_q;
  logic                    wr_en;
  logic [WIDTH-1:0]        wr_data;

  logic [31:0]             d_full;
  logic [ADDR_BITS-1:0]    d_eff;
  logic [ADDR_BITS-1:0]    rd_addr;
  logic [ADDR_BITS-1:0]    fill_inc;
  logic signed [PW-1:0]    mem_ext, coef_ext, prod_full;
  logic signed [WIDTH-1:0] result;

  // Delay in samples, clamped to the deepest slot the history RAM can hold.
  assign d_full   = 32'(delay_q) * 32'(SAMPLES_PER_STEP);
  assign d_eff    = (d_full > 32'(DEPTH - 1)) ? MAX_D : d_full[ADDR_BITS-1:0];
  assign rd_addr  = wr_ptr_q - d_eff;
  assign fill_inc = (fill_q < d_eff) ? fill_q + 1'b1 : d_eff;

  assign mem_ext   = PW'(mem_q);
  assign coef_ext  = $signed(PW'(coef_q));
  assign prod_full = mem_ext * coef_ext;

`ifdef ECHO_SATURATION_EN
  logic signed [WIDTH:0] sum;
  always_comb begin
    sum = (WIDTH+1)'(x_q) + (WIDTH+1)'(prod_q >>> 3);
    if (sum[WIDTH] != sum[WIDTH-1])
      result = sum[WIDTH] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
    else
      result = sum[WIDTH-1:0];
  end
`else
  assign result = x_q + WIDTH'(prod_q >>> 3);
`endif

  always_comb begin
    state_d      = state_q;
    x_d          = x_q;
    coef_d       = coef_q;
    delay_d      = delay_q;
    wr_ptr_d     = wr_ptr_q;
    fill_d       = fill_q;
    prod_d       = prod_q;
    sample_out_d = sample_out_q;
    done_d       = done_q;
    busy_d       = busy_q;
    wr_en        = 1'b0;
    wr_data      = '0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          x_d     = sample_in;
          coef_d  = coef;
          delay_d = delay_amount;
          // A new delay setting invalidates the history window already filled.
          if (delay_amount != delay_q) fill_d = '0;
          done_d  = 1'b0;
          busy_d  = 1'b1;
          state_d = (!enable || delay_amount == '0) ? S_BYPASS : S_READ;
        end
      end
      S_BYPASS: begin
        sample_out_d = x_q;
        wr_en        = 1'b1;
        wr_data      = x_q;
        wr_ptr_d     = wr_ptr_q + 1'b1;
        fill_d       = fill_inc;
        done_d       = 1'b1;
        busy_d       = 1'b0;
        state_d      = S_IDLE;
      end
      S_READ:  state_d = S_WAIT;
      S_WAIT:  state_d = S_SCALE;
      S_SCALE: begin
        prod_d  = (fill_q < d_eff) ? '0 : prod_full;
        state_d = S_COMBINE;
      end
      S_COMBINE: begin
        sample_out_d = result;
        wr_en        = 1'b1;
        wr_data      = result;
        wr_ptr_d     = wr_ptr_q + 1'b1;
        fill_d       = fill_inc;
        done_d       = 1'b1;
        busy_d       = 1'b0;
        state_d      = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= S_IDLE;
      x_q          <= '0;
      coef_q       <= '0;
      delay_q      <= '0;
      wr_ptr_q     <= '0;
      fill_q       <= '0;
      prod_q       <= '0;
      sample_out_q <= '0;
      done_q       <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      x_q          <= x_d;
      coef_q       <= coef_d;
      delay_q      <= delay_d;
      wr_ptr_q     <= wr_ptr_d;
      fill_q       <= fill_d;
      prod_q       <= prod_d;
      sample_out_q <= sample_out_d;
      done_q       <= done_d;
      busy_q       <= busy_d;
    end
  end

  // History RAM is deliberately not reset; the fill counter guards stale contents.
  always_ff @(posedge clock) begin
    if (wr_en) mem[wr_ptr_q] <= wr_data;
    if (state_q == S_READ) mem_q <= mem[rd_addr];
  end

  assign sample_out = sample_out_q;
  assign done       = done_q;
  assign busy       = busy_q;

endmodule
